sparc_exu_zpred_pipe: RTL and testbench

//  Pipelined, parametrised sum-zero predictor for the EXU ALU. Produces icc/xcc Z flags for rs1+rs2+cin or rs1-rs2 without a carry chain.

---
 rtl/sparc_exu_zpred_pipe_pkg.sv | 23 ++
 rtl/sparc_exu_zpred_chunk.sv | 24 ++
 rtl/sparc_exu_zpred_pipe.sv | 118 +++++++++++
 tb/tb_sparc_exu_zpred_pipe.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_zpred_pipe_pkg.sv
// Shared defaults, operation encoding and parameter legality helper for the
// pipelined sum-zero predictor.
package sparc_exu_zpred_pipe_pkg;

  localparam int unsigned ZP_WIDTH    = 64;
  localparam int unsigned ZP_LO_WIDTH = 32;
  localparam int unsigned ZP_CHUNK    = 8;
  localparam int unsigned ZP_TAG_W    = 2;

  typedef enum logic {
    ZP_ADD = 1'b0,
    ZP_SUB = 1'b1
  } zp_op_e;

  // Chunks must tile both the full operand and the icc low slice exactly.
  function automatic bit zp_params_ok(input int unsigned width,
                                      input int unsigned lo_width,
                                      input int unsigned chunk);
    return (chunk != 0) && (lo_width != 0) && (lo_width <= width) &&
           ((width % chunk) == 0) && ((lo_width % chunk) == 0);
  endfunction

endpackage

// File: rtl/sparc_exu_zpred_chunk.sv
// One CHUNK-bit slice of the zero predictor: flags any nonzero predict term
// p[i] = (a^b)[i] ^ (a|b)[i-1], with the slice's bit -1 supplied by i_cin.
module sparc_exu_zpred_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic             o_nz_c
);

  logic [CHUNK-1:0] w_prev;

  generate
    if (CHUNK == 1) begin : g_single
      assign w_prev = i_cin;
    end else begin : g_multi
      assign w_prev = {i_a[CHUNK-2:0] | i_b[CHUNK-2:0], i_cin};
    end
  endgenerate

  assign o_nz_c = |((i_a ^ i_b) ^ w_prev);

endmodule

// File: rtl/sparc_exu_zpred_pipe.sv
// Two-stage valid/ready zero predictor: stage 1 holds per-chunk nonzero flags,
// stage 2 holds the reduced xcc/icc Z flags and the returned tag.
module sparc_exu_zpred_pipe
  import sparc_exu_zpred_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = ZP_WIDTH,
  parameter int unsigned LO_WIDTH = ZP_LO_WIDTH,
  parameter int unsigned CHUNK    = ZP_CHUNK,
  parameter int unsigned TAG_W    = ZP_TAG_W
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zxcc,
  output logic             out_zicc,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned NCH    = WIDTH / CHUNK;
  localparam int unsigned LO_NCH = LO_WIDTH / CHUNK;

  generate
    if (!zp_params_ok(WIDTH, LO_WIDTH, CHUNK)) begin : g_bad_params
      $error("sparc_exu_zpred_pipe: CHUNK must divide WIDTH and LO_WIDTH, and LO_WIDTH <= WIDTH");
    end
  endgenerate

  zp_op_e           w_op;
  logic [WIDTH-1:0] w_b;
  logic             w_c;
  logic [NCH-1:0]   w_kcin;
  logic [NCH-1:0]   w_nz;
  logic             w_adv2;

  logic             r_s1_valid;
  logic [NCH-1:0]   r_s1_nz;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic             r_zxcc;
  logic             r_zicc;
  logic [TAG_W-1:0] r_tag;

  // Subtract is a + ~b + 1.
  assign w_op = zp_op_e'(in_sub);
  assign w_b  = (w_op == ZP_SUB) ? ~in_rs2 : in_rs2;
  assign w_c  = (w_op == ZP_SUB) ? 1'b1 : in_cin;

  // Each chunk sees the previous chunk's MSB generate/propagate as its bit -1.
  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_chunk
      if (k == 0) begin : g_c0
        assign w_kcin[k] = w_c;
      end else begin : g_cn
        assign w_kcin[k] = in_rs1[k*CHUNK-1] | w_b[k*CHUNK-1];
      end

      sparc_exu_zpred_chunk #(
        .CHUNK (CHUNK)
      ) u_chunk (
        .i_a    (in_rs1[k*CHUNK +: CHUNK]),
        .i_b    (w_b[k*CHUNK +: CHUNK]),
        .i_cin  (w_kcin[k]),
        .o_nz_c (w_nz[k])
      );
    end
  endgenerate

  assign w_adv2   = ~r_s2_valid | out_ready;
  assign in_ready = ~r_s1_valid | w_adv2;

  // Both stages shift together; flush empties them and drops the incoming beat.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_s1_valid <= 1'b0;
      r_s1_nz    <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_zxcc     <= 1'b0;
      r_zicc     <= 1'b0;
      r_tag      <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_zxcc <= ~|r_s1_nz;
          r_zicc <= ~|r_s1_nz[LO_NCH-1:0];
          r_tag  <= r_s1_tag;
        end
      end
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_nz  <= w_nz;
          r_s1_tag <= in_tag;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_zxcc  = r_zxcc;
  assign out_zicc  = r_zicc;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_sparc_exu_zpred_pipe.sv
// Bench for sparc_exu_zpred_pipe: directed latency/stall/flush scenarios plus a
// randomized run on 64/32/8 and 32/16/4 instances against an arithmetic model.
module tb_sparc_exu_zpred_pipe;

  logic        rclk = 1'b0;
  logic        arst_l;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        in_sub;
  logic        in_cin;
  logic [1:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_zxcc, out_zicc;
  logic [1:0]  out_tag;
  logic        in_ready32, out_valid32, out_zxcc32, out_zicc32;
  logic [1:0]  out_tag32;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         acc;
    logic       zx64;
    logic       zi64;
    logic       zx32;
    logic       zi32;
    logic [1:0] tag;
  } exp_t;

  exp_t q[$];

  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc <= cyc + 1;

  sparc_exu_zpred_pipe #(
    .WIDTH(64), .LO_WIDTH(32), .CHUNK(8), .TAG_W(2)
  ) dut (
    .rclk(rclk), .arst_l(arst_l), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_sub(in_sub), .in_cin(in_cin),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_zxcc(out_zxcc), .out_zicc(out_zicc), .out_tag(out_tag)
  );

  sparc_exu_zpred_pipe #(
    .WIDTH(32), .LO_WIDTH(16), .CHUNK(4), .TAG_W(2)
  ) dut32 (
    .rclk(rclk), .arst_l(arst_l), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_rs1(in_rs1[31:0]), .in_rs2(in_rs2[31:0]), .in_sub(in_sub), .in_cin(in_cin),
    .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_zxcc(out_zxcc32), .out_zicc(out_zicc32), .out_tag(out_tag32)
  );

  // Reference arithmetic: the true ALU result, from which Z flags follow directly.
  function automatic logic [63:0] golden(input logic [63:0] a, input logic [63:0] b,
                                         input logic sub, input logic cin);
    if (sub) return a - b;
    return a + b + 64'(cin);
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; flush = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_sub = 1'b0; in_cin = 1'b0; in_tag = '0;
  endtask

  task automatic drive_beat(input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic cin, input logic [1:0] tag);
    in_valid = 1'b1; in_rs1 = a; in_rs2 = b; in_sub = sub; in_cin = cin; in_tag = tag;
  endtask

  task automatic test_reset();
    arst_l = 1'b0; out_ready = 1'b1; drive_idle();
    repeat (2) @(negedge rclk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    n_checks++; if (out_zxcc !== 1'b0) begin n_fail++; $display("FAIL rst_zxcc: got %b exp 0", out_zxcc); end
    n_checks++; if (out_zicc !== 1'b0) begin n_fail++; $display("FAIL rst_zicc: got %b exp 0", out_zicc); end
    n_checks++; if (out_tag !== 2'd0) begin n_fail++; $display("FAIL rst_tag: got %0d exp 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    @(negedge rclk);
    arst_l = 1'b1;
  endtask

  task automatic test_single_latency();
    out_ready = 1'b1;
    @(negedge rclk);
    drive_beat(64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 2'd1);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b exp 1", in_ready); end
    @(negedge rclk);
    drive_idle();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid: got %b exp 0", out_valid); end
    @(negedge rclk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b exp 1", out_valid); end
    n_checks++; if (out_zxcc !== 1'b0) begin n_fail++; $display("FAIL lat_zxcc: got %b exp 0", out_zxcc); end
    n_checks++; if (out_zicc !== 1'b1) begin n_fail++; $display("FAIL lat_zicc: got %b exp 1", out_zicc); end
    n_checks++; if (out_tag !== 2'd1) begin n_fail++; $display("FAIL lat_tag: got %0d exp 1", out_tag); end
    @(negedge rclk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_retire: got %b exp 0", out_valid); end
  endtask

  task automatic test_zero_cases();
    logic [63:0] ta [3];
    logic [63:0] tb [3];
    logic        ts [3];
    logic        tc [3];
    logic        ezx [3];
    logic        ezi [3];
    ta[0] = 64'hDEAD_BEEF_0123_4567; tb[0] = 64'hDEAD_BEEF_0123_4567; ts[0] = 1'b1; tc[0] = 1'b0;
    ezx[0] = 1'b1; ezi[0] = 1'b1;
    ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'h0; ts[1] = 1'b0; tc[1] = 1'b1;
    ezx[1] = 1'b1; ezi[1] = 1'b1;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'h0; ts[2] = 1'b0; tc[2] = 1'b0;
    ezx[2] = 1'b0; ezi[2] = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge rclk);
      if (j < 3) drive_beat(ta[j], tb[j], ts[j], tc[j], 2'(j));
      else drive_idle();
      #1;
      if (j >= 2) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zc_valid[%0d]: got %b exp 1", j-2, out_valid); end
        n_checks++; if (out_zxcc !== ezx[j-2]) begin n_fail++; $display("FAIL zc_zxcc[%0d]: got %b exp %b", j-2, out_zxcc, ezx[j-2]); end
        n_checks++; if (out_zicc !== ezi[j-2]) begin n_fail++; $display("FAIL zc_zicc[%0d]: got %b exp %b", j-2, out_zicc, ezi[j-2]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, r;
    logic        ezx [8];
    logic        ezi [8];
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge rclk);
      if (j < 8) begin
        a = {$urandom(), $urandom()};
        b = (j % 2 == 1) ? -a : {$urandom(), $urandom()};
        r = golden(a, b, 1'b0, 1'b0);
        ezx[j] = (r == 64'd0);
        ezi[j] = (r[31:0] == 32'd0);
        drive_beat(a, b, 1'b0, 1'b0, 2'(j % 4));
      end else begin
        drive_idle();
      end
      #1;
      if (j < 8) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", j, in_ready); end
      end
      if (j >= 2) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b exp 1", j-2, out_valid); end
        n_checks++; if (out_tag !== 2'((j-2) % 4)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d exp %0d", j-2, out_tag, (j-2) % 4); end
        n_checks++; if (out_zxcc !== ezx[j-2]) begin n_fail++; $display("FAIL b2b_zxcc[%0d]: got %b exp %b", j-2, out_zxcc, ezx[j-2]); end
        n_checks++; if (out_zicc !== ezi[j-2]) begin n_fail++; $display("FAIL b2b_zicc[%0d]: got %b exp %b", j-2, out_zicc, ezi[j-2]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] a [3];
    logic [63:0] b [3];
    logic        ezx [3];
    logic        ezi [3];
    logic        eready [9];
    int          eidx [9];
    logic [63:0] r;
    for (int i = 0; i < 3; i++) begin
      a[i] = {$urandom(), $urandom()};
      b[i] = (i == 1) ? a[i] : {$urandom(), $urandom()};
      r = golden(a[i], b[i], 1'b1, 1'b0);
      ezx[i] = (r == 64'd0);
      ezi[i] = (r[31:0] == 32'd0);
    end
    // Per-cycle expectations: index of beat on the output (-1 = none) and in_ready.
    eidx   = '{-1, -1, 0, 0, 0, 0, 1, 2, -1};
    eready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 9; j++) begin
      @(negedge rclk);
      out_ready = (j >= 5);
      if (j < 3) drive_beat(a[j], b[j], 1'b1, 1'b0, 2'(j));
      else if (j >= 6) drive_idle();
      #1;
      n_checks++; if (in_ready !== eready[j]) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b exp %b", j, in_ready, eready[j]); end
      n_checks++; if (out_valid !== (eidx[j] >= 0)) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b exp %b", j, out_valid, eidx[j] >= 0); end
      if (eidx[j] >= 0) begin
        n_checks++; if (out_tag !== 2'(eidx[j])) begin n_fail++; $display("FAIL stall_tag[%0d]: got %0d exp %0d", j, out_tag, eidx[j]); end
        n_checks++; if (out_zxcc !== ezx[eidx[j]]) begin n_fail++; $display("FAIL stall_zxcc[%0d]: got %b exp %b", j, out_zxcc, ezx[eidx[j]]); end
        n_checks++; if (out_zicc !== ezi[eidx[j]]) begin n_fail++; $display("FAIL stall_zicc[%0d]: got %b exp %b", j, out_zicc, ezi[eidx[j]]); end
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge rclk);
      if (j < 3) drive_beat({$urandom(), $urandom()}, 64'h0, 1'b1, 1'b0, 2'(j));
      if (j == 2) flush = 1'b1;
      if (j == 3) begin drive_idle(); out_ready = 1'b1; end
      #1;
      if (j == 2) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_full_valid: got %b exp 1", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full_ready: got %b exp 0", in_ready); end
      end
      if (j >= 3) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid[%0d]: got %b exp 0", j, out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready[%0d]: got %b exp 1", j, in_ready); end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, ex, r;
    logic        s, c, fl, iv, ordy, exp_ov, exp_rdy;
    int          m;
    exp_t        e;
    q.delete();
    drive_idle();
    for (int it = 0; it < 3000; it++) begin
      @(negedge rclk);
      if (it == 1500) begin
        drive_idle();
        #1 arst_l = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_arst_valid: got %b exp 0", out_valid); end
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL rnd_arst_valid32: got %b exp 0", out_valid32); end
        q.delete();
        @(negedge rclk);
        arst_l = 1'b1;
      end
      a = {$urandom(), $urandom()};
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      ex = s ? a : (~a + 64'd1 - 64'(c));
      m = $urandom_range(0, 3);
      case (m)
        0: b = {$urandom(), $urandom()};
        1: b = ex;
        2: b = ex ^ {32'($urandom()), 32'h0};
        default: b = ex ^ {48'({$urandom(), $urandom()}), 16'h0};
      endcase
      fl   = ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 3) != 0);
      in_valid = iv; in_rs1 = a; in_rs2 = b; in_sub = s; in_cin = c;
      in_tag = 2'($urandom_range(0, 3)); flush = fl; out_ready = ordy;
      #1;
      exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + 1);
      exp_rdy = (q.size() < 2) || ordy;
      n_checks++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b exp %b", it, out_valid, exp_ov); end
      n_checks++; if (out_valid32 !== exp_ov) begin n_fail++; $display("FAIL rnd_valid32@%0d: got %b exp %b", it, out_valid32, exp_ov); end
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b exp %b", it, in_ready, exp_rdy); end
      n_checks++; if (in_ready32 !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready32@%0d: got %b exp %b", it, in_ready32, exp_rdy); end
      if (exp_ov) begin
        n_checks++;
        if ({out_zxcc, out_zicc, out_tag} !== {q[0].zx64, q[0].zi64, q[0].tag}) begin
          n_fail++;
          $display("FAIL rnd_res64@%0d: got zx=%b zi=%b tag=%0d exp zx=%b zi=%b tag=%0d",
                   it, out_zxcc, out_zicc, out_tag, q[0].zx64, q[0].zi64, q[0].tag);
        end
        n_checks++;
        if ({out_zxcc32, out_zicc32, out_tag32} !== {q[0].zx32, q[0].zi32, q[0].tag}) begin
          n_fail++;
          $display("FAIL rnd_res32@%0d: got zx=%b zi=%b tag=%0d exp zx=%b zi=%b tag=%0d",
                   it, out_zxcc32, out_zicc32, out_tag32, q[0].zx32, q[0].zi32, q[0].tag);
        end
      end
      if (fl) begin
        q.delete();
      end else begin
        if (exp_ov && ordy) void'(q.pop_front());
        if (iv && exp_rdy) begin
          r = golden(a, b, s, c);
          e.acc  = cyc + 1;
          e.zx64 = (r == 64'd0);
          e.zi64 = (r[31:0] == 32'd0);
          e.zx32 = (r[31:0] == 32'd0);
          e.zi32 = (r[15:0] == 16'd0);
          e.tag  = in_tag;
          q.push_back(e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_zero_cases();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
